// File: rtl/usb_rst_sequencer.sv
// Avalon-MM timed reset sequencer for the USB host chip: pulse, recovery, then ready.
// Optional level interrupt on DONE is built when USB_RST_IRQ_EN is defined.
module usb_rst_sequencer #(
   parameter int unsigned CNT_W           = 24,
   parameter int unsigned PULSE_DEFAULT   = 50000,
   parameter int unsigned RECOVER_DEFAULT = 500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        usb_rst_n
`ifdef USB_RST_IRQ_EN
   ,
   output logic        irq
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2,
      ST_READY   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
   logic [CNT_W-1:0] recover_len_q, recover_len_d;
   logic             done_q, done_d;
   logic             usb_rst_n_q, usb_rst_n_d;
   logic             irq_en;
   logic             wr, start_wr, clear_wr, done_clr_wr;
   logic             busy, ready;
   logic             unused_wdata;

`ifdef USB_RST_IRQ_EN
   logic irq_en_q, irq_en_d;
   assign irq_en = irq_en_q;
`else
   assign irq_en = 1'b0;
`endif

   assign unused_wdata = ^writedata;

   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   // State and register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_ASSERT;
         cnt_q         <= at_least_one(CNT_W'(PULSE_DEFAULT));
         pulse_len_q   <= CNT_W'(PULSE_DEFAULT);
         recover_len_q <= CNT_W'(RECOVER_DEFAULT);
         done_q        <= 1'b0;
         usb_rst_n_q   <= 1'b0;
`ifdef USB_RST_IRQ_EN
         irq_en_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pulse_len_q   <= pulse_len_d;
         recover_len_q <= recover_len_d;
         done_q        <= done_d;
         usb_rst_n_q   <= usb_rst_n_d;
`ifdef USB_RST_IRQ_EN
         irq_en_q      <= irq_en_d;
`endif
      end
   end

   // Next-state and register-update logic
   always_comb begin
      wr          = chipselect & ~write_n;
      start_wr    = wr && (address == 2'd0) && writedata[0];
      clear_wr    = wr && (address == 2'd0) && writedata[2];
      done_clr_wr = wr && (address == 2'd3) && writedata[2];

      state_d       = state_q;
      cnt_d         = cnt_q;
      pulse_len_d   = pulse_len_q;
      recover_len_d = recover_len_q;
      done_d        = done_q;
`ifdef USB_RST_IRQ_EN
      irq_en_d      = irq_en_q;
      if (wr && (address == 2'd0)) irq_en_d = writedata[1];
`endif

      if (wr && (address == 2'd1)) pulse_len_d   = writedata[CNT_W-1:0];
      if (wr && (address == 2'd2)) recover_len_d = writedata[CNT_W-1:0];
      if (done_clr_wr)             done_d        = 1'b0;

      // DONE set is applied after the W1C so a same-edge set wins
      case (state_q)
         ST_ASSERT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RECOVER;
               cnt_d   = at_least_one(recover_len_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RECOVER: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_READY;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_READY: begin
            if (start_wr) begin
               state_d = ST_ASSERT;
               cnt_d   = at_least_one(pulse_len_q);
               done_d  = 1'b0;
            end else if (clear_wr) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (start_wr) begin
               state_d = ST_ASSERT;
               cnt_d   = at_least_one(pulse_len_q);
               done_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and read mux
   always_comb begin
      busy        = (state_q == ST_ASSERT) || (state_q == ST_RECOVER);
      ready       = (state_q == ST_READY);
      usb_rst_n_d = (state_d != ST_ASSERT);
      usb_rst_n   = usb_rst_n_q;
`ifdef USB_RST_IRQ_EN
      irq         = done_q & irq_en_q;
`endif
      case (address)
         2'd0:    readdata = {30'b0, irq_en, 1'b0};
         2'd1:    readdata = 32'(pulse_len_q);
         2'd2:    readdata = 32'(recover_len_q);
         default: readdata = {26'b0, 2'(state_q), 1'b0, done_q, ready, busy};
      endcase
   end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Self-checking bench for usb_rst_sequencer: timeline model compared every cycle
// plus literal checkpoints; IRQ section built when USB_RST_IRQ_EN is defined.
module tb_usb_rst_sequencer;

   localparam int unsigned PD = 4;
   localparam int unsigned RD = 6;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [1:0]  address    = 2'd3;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = '0;
   logic [31:0] readdata;
   logic        usb_rst_n;
`ifdef USB_RST_IRQ_EN
   logic        irq;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   usb_rst_sequencer #(
      .CNT_W(24),
      .PULSE_DEFAULT(PD),
      .RECOVER_DEFAULT(RD)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .usb_rst_n(usb_rst_n)
`ifdef USB_RST_IRQ_EN
      ,
      .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   // Model: a sequence is a start cycle plus pulse/recover lengths; phase follows from elapsed cycles
   int          cyc       = 0;
   int          seq_start = 0;
   int          seq_p     = PD;
   int          seq_r     = 0;
   bit          m_idle    = 1'b0;
   bit          m_done    = 1'b0;
   bit          m_irq_en  = 1'b0;
   logic [23:0] m_pulse   = 24'(PD);
   logic [23:0] m_recover = 24'(RD);

   function automatic int eff(input logic [23:0] v);
      return (v == 24'd0) ? 1 : int'(v);
   endfunction

   // 0 idle, 1 pulse, 2 recovery, 3 ready
   function automatic int phase_at(input int c);
      int e;
      if (m_idle) return 0;
      e = c - seq_start;
      if (e < seq_p) return 1;
      if (e < seq_p + seq_r) return 2;
      return 3;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      logic [31:0] r;
      int ph;
      r  = '0;
      ph = phase_at(cyc);
      case (a)
         2'd0: r[1] = m_irq_en;
         2'd1: r[23:0] = m_pulse;
         2'd2: r[23:0] = m_recover;
         default: begin
            r[0]   = (ph == 1) || (ph == 2);
            r[1]   = (ph == 3);
            r[2]   = m_done;
            r[5:4] = 2'(ph);
         end
      endcase
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      int  ph_old, k;
      bit  w, start, clear, set_done;
      if (!reset_n) begin
         cyc = 0; seq_start = 0; seq_p = eff(24'(PD)); seq_r = 0;
         m_idle = 1'b0; m_done = 1'b0; m_irq_en = 1'b0;
         m_pulse = 24'(PD); m_recover = 24'(RD);
      end else begin
         ph_old   = phase_at(cyc);
         k        = cyc + 1;
         w        = chipselect && !write_n;
         start    = w && (address == 2'd0) && writedata[0] && (ph_old == 0 || ph_old == 3);
         clear    = w && (address == 2'd0) && writedata[2] && (ph_old == 3) && !start;
         set_done = (ph_old == 2) && (k - seq_start == seq_p + seq_r);
         if (ph_old == 1 && (k - seq_start == seq_p)) seq_r = eff(m_recover);
         if (w && (address == 2'd3) && writedata[2]) m_done = 1'b0;
         if (set_done) m_done = 1'b1;
         if (start) begin
            seq_start = k; seq_p = eff(m_pulse); seq_r = 0; m_idle = 1'b0; m_done = 1'b0;
         end
         if (clear) m_idle = 1'b1;
         if (w && (address == 2'd1)) m_pulse   = writedata[23:0];
         if (w && (address == 2'd2)) m_recover = writedata[23:0];
`ifdef USB_RST_IRQ_EN
         if (w && (address == 2'd0)) m_irq_en = writedata[1];
`endif
         cyc = k;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("usb_rst_n", {31'b0, usb_rst_n}, {31'b0, phase_at(cyc) != 1});
      check("readdata", readdata, exp_rd(address));
`ifdef USB_RST_IRQ_EN
      check("irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
`endif
   end

   int low_run  = 0;
   int last_low = 0;
   always @(negedge clk) begin
      if (!reset_n) low_run = 0;
      else if (!usb_rst_n) low_run++;
      else if (low_run != 0) begin
         last_low = low_run;
         low_run  = 0;
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      #1 chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      #1 chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = 2'd3;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2 check("rst_status", readdata, 32'h11);
      check("rst_usb", {31'b0, usb_rst_n}, 32'd0);

      // power-up sequence
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      #2 check("pwr_recover", readdata, 32'h21);
      @(negedge clk);
      #2 check("pwr_ready", readdata, 32'h36);
      check("pwr_width", 32'(last_low), 32'd4);
      @(negedge clk);
      #1 address = 2'd2;
      #1 check("recover_default", readdata, 32'd6);
      address = 2'd0;
      #1 check("control_reset", readdata, 32'd0);
      address = 2'd3;

      // software retrigger
      wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd0, 32'd1);
      #1 check("rt_assert", readdata, 32'h11);
      repeat (4) @(negedge clk);
      #2 check("rt_recover", readdata, 32'h21);
      @(negedge clk);
      #2 check("rt_ready", readdata, 32'h36);
      check("rt_width", 32'(last_low), 32'd3);

      // START and PULSE_LEN writes while busy do not alter the running sequence
      wr(2'd1, 32'd5); wr(2'd0, 32'd1); wr(2'd0, 32'd1); wr(2'd1, 32'd1);
      repeat (3) @(negedge clk);
      #2 check("busy_ready", readdata, 32'h36);
      check("busy_width", 32'(last_low), 32'd5);
      wr(2'd3, 32'd4);
      #1 check("done_w1c", readdata, 32'h32);
      repeat (3) @(negedge clk);
      #2 check("single_done", readdata, 32'h32);

      // zero lengths act as one cycle each
      wr(2'd1, 32'd0); wr(2'd2, 32'd0); wr(2'd0, 32'd1);
      #1 check("zero_assert", readdata, 32'h11);
      @(negedge clk);
      #2 check("zero_recover", readdata, 32'h21);
      @(negedge clk);
      #2 check("zero_ready", readdata, 32'h36);
      check("zero_width", 32'(last_low), 32'd1);

      // CLEAR to idle, then start from idle
      wr(2'd0, 32'd4);
      #1 check("clear_idle", readdata, 32'h04);
      check("clear_usb", {31'b0, usb_rst_n}, 32'd1);
      wr(2'd0, 32'd4);
      #1 check("clear_again", readdata, 32'h04);
      wr(2'd0, 32'd1);
      #1 check("idle_start", readdata, 32'h11);
      repeat (2) @(negedge clk);
      #2 check("idle_ready", readdata, 32'h36);

      // DONE set and W1C on the same edge: set wins
      wr(2'd1, 32'd2); wr(2'd2, 32'd2); wr(2'd0, 32'd1);
      repeat (2) @(negedge clk);
      wr(2'd3, 32'd4);
      #1 check("set_wins", readdata, 32'h36);

`ifdef USB_RST_IRQ_EN
      wr(2'd0, 32'd2);
      #1 address = 2'd0;
      #1 check("irq_en_rd", readdata, 32'd2);
      address = 2'd3;
      wr(2'd3, 32'd4);
      #1 check("irq_cleared", {31'b0, irq}, 32'd0);
      wr(2'd0, 32'd3);
      repeat (3) @(negedge clk);
      #2 check("irq_busy", {31'b0, irq}, 32'd0);
      @(negedge clk);
      #2 check("irq_rise", {31'b0, irq}, 32'd1);
      wr(2'd3, 32'd4);
      #1 check("irq_w1c", {31'b0, irq}, 32'd0);
`endif

      // reset during recovery restarts the power-up sequence
      wr(2'd1, 32'd3); wr(2'd2, 32'd5); wr(2'd0, 32'd1);
      repeat (4) @(negedge clk);
      #1 reset_n = 1'b0; address = 2'd1;
      #1 check("midrst_usb", {31'b0, usb_rst_n}, 32'd0);
      check("midrst_pulse", readdata, 32'd4);
      address = 2'd3;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      #2 check("rerun_recover", readdata, 32'h21);
      @(negedge clk);
      #2 check("rerun_ready", readdata, 32'h36);
      check("rerun_width", 32'(last_low), 32'd4);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
